ivl_ovl_window_mc: RTL and testbench

Multi-channel, parametrised successor to the single-bit OVL window checker. Per channel, it watches a start/end event pair and checks a multi-bit test expression throughout each window, in either "all-true" or "stable" mode. It also bounds window length (minimum and maximum cycles) and reports violations as registered per-channel fire pulses with a type code. It sits beside DUT interfaces in the ivl_uvm OVL bench set, driven by the shared clock generator.

---
 rtl/ivl_ovl_window_mc_pkg.sv | 18 +
 rtl/ivl_ovl_window_mc_if.sv | 26 ++
 rtl/ivl_ovl_window_mc_ch.sv | 93 +++++++++
 rtl/ivl_ovl_window_mc.sv | 63 ++++++
 tb/tb_ivl_ovl_window_mc.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ivl_ovl_window_mc_pkg.sv
// Shared types and constants for the multi-channel OVL window checker.
package ivl_ovl_pkg;

  localparam int unsigned FCNT_W = 16;

  typedef enum logic [1:0] {
    FT_NONE    = 2'b00,
    FT_VALUE   = 2'b01,
    FT_EARLY   = 2'b10,
    FT_TIMEOUT = 2'b11
  } fire_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } ch_state_e;

endpackage

// File: rtl/ivl_ovl_window_mc_if.sv
// Event, expression and violation-report bundle for ivl_ovl_window_mc.
interface ivl_ovl_window_mc_if
  import ivl_ovl_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
);
  logic                    enable;
  logic [NUM_CH-1:0]       start_event;
  logic [NUM_CH-1:0]       end_event;
  logic [NUM_CH*WIDTH-1:0] test_expr;
  logic [NUM_CH-1:0]       window_open;
  logic [NUM_CH-1:0]       fire;
  logic [2*NUM_CH-1:0]     fire_type;
  logic [FCNT_W-1:0]       fire_count;

  modport master (
    output enable, start_event, end_event, test_expr,
    input  window_open, fire, fire_type, fire_count
  );

  modport slave (
    input  enable, start_event, end_event, test_expr,
    output window_open, fire, fire_type, fire_count
  );
endinterface

// File: rtl/ivl_ovl_window_mc_ch.sv
// One window-checker channel: IDLE/OPEN FSM, length counter, captured value and fire register.
module ivl_ovl_window_ch
  import ivl_ovl_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODE    = 0,
  parameter int unsigned MIN_CKS = 0,
  parameter int unsigned MAX_CKS = 16,
  parameter int unsigned CNT_W   = $clog2(MAX_CKS + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start_event,
  input  logic             end_event,
  input  logic [WIDTH-1:0] slice,
  output logic             window_open,
  output logic             fire,
  output logic [1:0]       fire_type
);
  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_CKS);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_CKS + 1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] len_q, l_cur;
  logic [WIDTH-1:0] ref_q;
  logic             vflag_q;
  logic             val_bad;
  logic             timeout;
  fire_type_e       ftype_d;

  // l_cur is the window length including the cycle being sampled
  assign l_cur       = len_q + 1'b1;
  assign timeout     = (MAX_CKS != 0) && (l_cur == MAX_L);
  assign window_open = (state_q == ST_OPEN);
  assign val_bad     = (MODE == 0) ? (slice != '1) : (slice != ref_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_event) state_d = ST_OPEN;
        ST_OPEN: if (end_event || timeout) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ftype_d = FT_NONE;
    if (enable && state_q == ST_OPEN) begin
      if (!end_event && timeout)
        ftype_d = FT_TIMEOUT;
      else if (end_event && MIN_CKS != 0 && l_cur < MIN_L)
        ftype_d = FT_EARLY;
      else if (val_bad && !vflag_q)
        ftype_d = FT_VALUE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      ref_q     <= '0;
      vflag_q   <= 1'b0;
      fire      <= 1'b0;
      fire_type <= FT_NONE;
    end else begin
      fire      <= (ftype_d != FT_NONE);
      fire_type <= ftype_d;
      if (!enable) begin
        len_q   <= '0;
        vflag_q <= 1'b0;
      end else if (state_q == ST_IDLE) begin
        if (start_event) begin
          len_q   <= '0;
          vflag_q <= 1'b0;
          ref_q   <= slice;
        end
      end else begin
        len_q   <= l_cur;
        vflag_q <= vflag_q | val_bad;
      end
    end
  end
endmodule

// File: rtl/ivl_ovl_window_mc.sv
// Multi-channel OVL window checker top: per-channel slicing, saturating fire counter.
// Optional IVL_OVL_WINDOW_MSG_EN enables simulation-only $error messages on each violation.
module ivl_ovl_window_mc
  import ivl_ovl_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODE    = 0,
  parameter int unsigned MIN_CKS = 0,
  parameter int unsigned MAX_CKS = 16,
  parameter int unsigned CNT_W   = $clog2(MAX_CKS + 2)
) (
  input logic clock,
  input logic reset,
  ivl_ovl_window_mc_if.slave bus
);
  logic [NUM_CH-1:0]   open_w;
  logic [NUM_CH-1:0]   fire_w;
  logic [2*NUM_CH-1:0] ftype_w;
  logic [FCNT_W-1:0]   cnt_q, pc;
  logic [FCNT_W:0]     sum;

  for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
    ivl_ovl_window_ch #(
      .WIDTH   (WIDTH),
      .MODE    (MODE),
      .MIN_CKS (MIN_CKS),
      .MAX_CKS (MAX_CKS),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .enable      (bus.enable),
      .start_event (bus.start_event[c]),
      .end_event   (bus.end_event[c]),
      .slice       (bus.test_expr[c*WIDTH +: WIDTH]),
      .window_open (open_w[c]),
      .fire        (fire_w[c]),
      .fire_type   (ftype_w[2*c +: 2])
    );

`ifdef IVL_OVL_WINDOW_MSG_EN
    always @(posedge clock) begin
      if (!reset && u_ch.ftype_d != FT_NONE)
        $error("%0t %m ch%0d %s len=%0d slice=%h", $time, c, u_ch.ftype_d.name(),
               u_ch.l_cur, bus.test_expr[c*WIDTH +: WIDTH]);
    end
`endif
  end

  assign pc  = FCNT_W'($countones(fire_w));
  assign sum = {1'b0, cnt_q} + {1'b0, pc};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= sum[FCNT_W] ? '1 : sum[FCNT_W-1:0];
  end

  assign bus.window_open = open_w;
  assign bus.fire        = fire_w;
  assign bus.fire_type   = ftype_w;
  assign bus.fire_count  = cnt_q;
endmodule

// File: tb/tb_ivl_ovl_window_mc.sv
// Directed bench for ivl_ovl_window_mc: three configurations driven from one clock and reset.
module tb_ivl_ovl_window_mc;
  import ivl_ovl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ivl_ovl_window_mc_if #(.NUM_CH(4), .WIDTH(8)) if0 ();
  ivl_ovl_window_mc_if #(.NUM_CH(4), .WIDTH(8)) if1 ();
  ivl_ovl_window_mc_if #(.NUM_CH(4), .WIDTH(8)) if2 ();

  ivl_ovl_window_mc #(.NUM_CH(4), .WIDTH(8), .MODE(0), .MIN_CKS(0), .MAX_CKS(16))
    dut0 (.clock(clk), .reset(rst), .bus(if0.slave));
  ivl_ovl_window_mc #(.NUM_CH(4), .WIDTH(8), .MODE(1), .MIN_CKS(0), .MAX_CKS(16))
    dut1 (.clock(clk), .reset(rst), .bus(if1.slave));
  ivl_ovl_window_mc #(.NUM_CH(4), .WIDTH(8), .MODE(0), .MIN_CKS(4), .MAX_CKS(8))
    dut2 (.clock(clk), .reset(rst), .bus(if2.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    if0.enable = 1'b1; if0.start_event = '0; if0.end_event = '0; if0.test_expr = '1;
    if1.enable = 1'b1; if1.start_event = '0; if1.end_event = '0; if1.test_expr = '0;
    if2.enable = 1'b1; if2.start_event = '0; if2.end_event = '0; if2.test_expr = '1;
    #1 rst = 1'b1;
    #2;
    total++;
    if ({if0.window_open, if0.fire, if0.fire_type, if0.fire_count} !== 32'd0) begin
      bad++; $display("FAIL reset_dut0: got %h expected 0", {if0.window_open, if0.fire, if0.fire_type, if0.fire_count});
    end
    total++;
    if ({if1.window_open, if1.fire, if1.fire_type, if1.fire_count,
         if2.window_open, if2.fire, if2.fire_type, if2.fire_count} !== 64'd0) begin
      bad++; $display("FAIL reset_dut12: got %h %h expected 0",
                      {if1.window_open, if1.fire, if1.fire_type, if1.fire_count},
                      {if2.window_open, if2.fire, if2.fire_type, if2.fire_count});
    end
    tick;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    if0.start_event = 4'b0001; tick; if0.start_event = '0;
    for (int i = 1; i <= 5; i++) begin
      total++;
      if ({if0.window_open[0], if0.fire} !== 5'b10000) begin
        bad++; $display("FAIL basic_open L=%0d: got %b expected 10000", i, {if0.window_open[0], if0.fire});
      end
      if0.end_event = (i == 5) ? 4'b0001 : 4'b0000;
      tick;
    end
    if0.end_event = '0;
    total++;
    if ({if0.window_open, if0.fire, if0.fire_count} !== 24'd0) begin
      bad++; $display("FAIL basic_close: got %h expected 0", {if0.window_open, if0.fire, if0.fire_count});
    end
  endtask

  task automatic test_value_mode0;
    logic [3:0] exp;
    if0.start_event = 4'b0001; tick; if0.start_event = '0;
    for (int l = 1; l <= 6; l++) begin
      if0.test_expr[7:0] = (l == 3 || l == 4) ? 8'hFE : 8'hFF;
      if0.end_event = (l == 6) ? 4'b0001 : 4'b0000;
      tick;
      exp = {(l < 6), (l == 3), (l == 3) ? 2'b01 : 2'b00};
      total++;
      if ({if0.window_open[0], if0.fire[0], if0.fire_type[1:0]} !== exp) begin
        bad++; $display("FAIL value0 L=%0d: got %b expected %b", l,
                        {if0.window_open[0], if0.fire[0], if0.fire_type[1:0]}, exp);
      end
    end
    if0.end_event = '0; if0.test_expr = '1;
    tick;
    total++;
    if (if0.fire_count !== 16'd1) begin
      bad++; $display("FAIL value0_count: got %0d expected 1", if0.fire_count);
    end
  endtask

  task automatic test_same_cycle;
    if0.start_event = 4'b0101; tick; if0.start_event = '0;
    tick;
    total++;
    if (if0.window_open !== 4'b0101) begin
      bad++; $display("FAIL multi_open: got %b expected 0101", if0.window_open);
    end
    if0.test_expr = 32'hFFFEFFFE;
    tick;
    total++;
    if ({if0.fire, if0.fire_type} !== 12'b0101_00010001) begin
      bad++; $display("FAIL multi_fire: got %b expected 010100010001", {if0.fire, if0.fire_type});
    end
    if0.end_event = 4'b0101;
    tick;
    if0.end_event = '0; if0.test_expr = '1;
    total++;
    if ({if0.window_open, if0.fire, if0.fire_count} !== {8'h00, 16'd3}) begin
      bad++; $display("FAIL multi_count: got %h expected 0003", {if0.window_open, if0.fire, if0.fire_count});
    end
  endtask

  task automatic test_start_end_idle;
    if0.start_event = 4'b0010; if0.end_event = 4'b0010; tick;
    if0.start_event = '0; if0.end_event = '0;
    total++;
    if ({if0.window_open, if0.fire} !== 8'b0010_0000) begin
      bad++; $display("FAIL start_end_same: got %b expected 00100000", {if0.window_open, if0.fire});
    end
    if0.end_event = 4'b0010; tick;
    tick;
    if0.end_event = '0;
    total++;
    if ({if0.window_open, if0.fire} !== 8'd0) begin
      bad++; $display("FAIL end_idle: got %b expected 0", {if0.window_open, if0.fire});
    end
  endtask

  task automatic test_mode1;
    if1.test_expr[7:0] = 8'hA5;
    if1.start_event = 4'b0001; tick; if1.start_event = '0;
    tick;
    total++;
    if ({if1.window_open[0], if1.fire} !== 5'b10000) begin
      bad++; $display("FAIL mode1_hold: got %b expected 10000", {if1.window_open[0], if1.fire});
    end
    if1.test_expr[7:0] = 8'hA4;
    tick;
    total++;
    if ({if1.fire, if1.fire_type} !== 12'b0001_00000001) begin
      bad++; $display("FAIL mode1_value: got %b expected 000100000001", {if1.fire, if1.fire_type});
    end
    if1.end_event = 4'b0001; tick; if1.end_event = '0;
    total++;
    if ({if1.window_open[0], if1.fire} !== 5'b00000) begin
      bad++; $display("FAIL mode1_once: got %b expected 00000", {if1.window_open[0], if1.fire});
    end
    if1.test_expr[7:0] = 8'h3C;
    if1.start_event = 4'b0001; tick; if1.start_event = '0;
    for (int l = 1; l <= 4; l++) begin
      if1.end_event = (l == 4) ? 4'b0001 : 4'b0000;
      tick;
      total++;
      if ({if1.window_open[0], if1.fire} !== {(l < 4), 4'b0000}) begin
        bad++; $display("FAIL mode1_stable L=%0d: got %b expected %b", l,
                        {if1.window_open[0], if1.fire}, {(l < 4), 4'b0000});
      end
    end
    if1.end_event = '0;
    total++;
    if (if1.fire_count !== 16'd1) begin
      bad++; $display("FAIL mode1_count: got %0d expected 1", if1.fire_count);
    end
  endtask

  task automatic test_bounds;
    int         ends [4] = '{3, 4, 8, 1};
    logic [1:0] codes[4] = '{2'b10, 2'b00, 2'b00, 2'b10};
    logic [3:0] exp;
    for (int k = 0; k < 4; k++) begin
      if2.start_event = 4'b0001; tick; if2.start_event = '0;
      for (int l = 1; l <= ends[k]; l++) begin
        if2.end_event = (l == ends[k]) ? 4'b0001 : 4'b0000;
        tick;
        exp = (l < ends[k]) ? 4'b1000 : {1'b0, (codes[k] != 2'b00), codes[k]};
        total++;
        if ({if2.window_open[0], if2.fire[0], if2.fire_type[1:0]} !== exp) begin
          bad++; $display("FAIL bounds_end%0d L=%0d: got %b expected %b", ends[k], l,
                          {if2.window_open[0], if2.fire[0], if2.fire_type[1:0]}, exp);
        end
      end
      if2.end_event = '0;
      tick;
    end
    if2.start_event = 4'b0001; tick; if2.start_event = '0;
    for (int l = 1; l <= 9; l++) begin
      tick;
      exp = (l < 9) ? 4'b1000 : 4'b0111;
      total++;
      if ({if2.window_open[0], if2.fire[0], if2.fire_type[1:0]} !== exp) begin
        bad++; $display("FAIL timeout L=%0d: got %b expected %b", l,
                        {if2.window_open[0], if2.fire[0], if2.fire_type[1:0]}, exp);
      end
    end
    tick;
    total++;
    if ({if2.window_open, if2.fire} !== 8'd0) begin
      bad++; $display("FAIL timeout_closed: got %b expected 0", {if2.window_open, if2.fire});
    end
    if2.start_event = 4'b0001; tick; if2.start_event = '0;
    tick;
    if2.test_expr[7:0] = 8'hFE; if2.end_event = 4'b0001;
    tick;
    if2.test_expr = '1; if2.end_event = '0;
    total++;
    if ({if2.window_open[0], if2.fire[0], if2.fire_type[1:0]} !== 4'b0110) begin
      bad++; $display("FAIL early_over_value: got %b expected 0110",
                      {if2.window_open[0], if2.fire[0], if2.fire_type[1:0]});
    end
    tick;
    total++;
    if (if2.fire_count !== 16'd4) begin
      bad++; $display("FAIL bounds_count: got %0d expected 4", if2.fire_count);
    end
  endtask

  task automatic test_restart_ignored;
    if2.start_event = 4'b0001; tick; if2.start_event = '0;
    tick; tick;
    if2.start_event = 4'b0001; tick; if2.start_event = '0;
    if2.end_event = 4'b0001; tick; if2.end_event = '0;
    total++;
    if ({if2.window_open[0], if2.fire[0], if2.fire_type[1:0]} !== 4'b0000) begin
      bad++; $display("FAIL no_restart: got %b expected 0000",
                      {if2.window_open[0], if2.fire[0], if2.fire_type[1:0]});
    end
  endtask

  task automatic test_enable;
    if2.start_event = 4'b0001; tick; if2.start_event = '0;
    tick;
    if2.enable = 1'b0; if2.test_expr[7:0] = 8'hFE;
    tick;
    total++;
    if ({if2.window_open, if2.fire} !== 8'd0) begin
      bad++; $display("FAIL disable_idle: got %b expected 0", {if2.window_open, if2.fire});
    end
    if2.start_event = 4'b0001;
    tick;
    total++;
    if ({if2.window_open, if2.fire, if2.fire_count} !== {8'd0, 16'd4}) begin
      bad++; $display("FAIL disable_hold: got %h expected 0004", {if2.window_open, if2.fire, if2.fire_count});
    end
    if2.enable = 1'b1; if2.test_expr = '1;
    tick; if2.start_event = '0;
    total++;
    if (if2.window_open !== 4'b0001) begin
      bad++; $display("FAIL reenable_open: got %b expected 0001", if2.window_open);
    end
    for (int l = 1; l <= 4; l++) begin
      if2.end_event = (l == 4) ? 4'b0001 : 4'b0000;
      tick;
      total++;
      if ({if2.window_open[0], if2.fire} !== {(l < 4), 4'b0000}) begin
        bad++; $display("FAIL reenable_win L=%0d: got %b expected %b", l,
                        {if2.window_open[0], if2.fire}, {(l < 4), 4'b0000});
      end
    end
    if2.end_event = '0;
  endtask

  task automatic test_reset_mid;
    if0.start_event = 4'b0001; tick; if0.start_event = '0;
    tick;
    if0.test_expr[7:0] = 8'hFE;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({if0.window_open, if0.fire, if0.fire_count} !== 24'd0) begin
      bad++; $display("FAIL reset_mid: got %h expected 0", {if0.window_open, if0.fire, if0.fire_count});
    end
    #1 rst = 1'b0;
    if0.test_expr = '1;
    if0.start_event = 4'b0001; tick; if0.start_event = '0;
    total++;
    if ({if0.window_open, if0.fire} !== 8'b0001_0000) begin
      bad++; $display("FAIL reset_first_start: got %b expected 00010000", {if0.window_open, if0.fire});
    end
    if0.end_event = 4'b0001; tick; if0.end_event = '0;
    total++;
    if ({if0.window_open, if0.fire, if0.fire_count} !== 24'd0) begin
      bad++; $display("FAIL reset_fresh_close: got %h expected 0", {if0.window_open, if0.fire, if0.fire_count});
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_value_mode0;
    test_same_cycle;
    test_start_end_idle;
    test_mode1;
    test_bounds;
    test_restart_ignored;
    test_enable;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
